module_bcd_binario: RTL and testbench

Converts a four-digit BCD value (thousands, hundreds, tens, units) into a 16-bit unsigned binary number using an iterative multiply-by-10-and-add datapath. It is the inverse of the binary-to-digits divider that feeds the seven-segment display path. It sits between digit-entry logic (keypad or digit counters) and the binary arithmetic core, and uses a start/done handshake.

---
 rtl/module_bcd_binario.sv | 133 +++++++++++++
 tb/tb_module_bcd_binario.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_bcd_binario.sv
// Four-digit BCD to 16-bit binary converter: one multiply-by-10-and-add step per clock, start/done handshake.
// Optional invalid-digit detection is compiled in with `define BCD_DIGIT_CHECK_EN.
module module_bcd_binario (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_input,
  input  logic [3:0]  unidades_input,
  input  logic [3:0]  decenas_input,
  input  logic [3:0]  centenas_input,
  input  logic [3:0]  milesimas_input,
  output logic [15:0] numero_output,
  output logic        busy_output,
  output logic        done_output,
  output logic        error_output
);

  localparam int DATA_W = 16;
  localparam int DIG_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;

  // dig_p0[3] = thousands ... dig_p0[0] = units
  logic [3:0][DIG_W-1:0] dig_p0;
  logic [1:0]            idx_p0;
  logic [DATA_W-1:0]     acc_p1;

  // x10 built from shifts so no multiplier is inferred; operands stay unsigned
  function automatic logic [DATA_W-1:0] mul10_add(input logic [DATA_W-1:0] acc,
                                                  input logic [DIG_W-1:0]  dig);
    logic [DATA_W-1:0] x8;
    logic [DATA_W-1:0] x2;
    x8 = acc << 3;
    x2 = acc << 1;
    return x8 + x2 + {{(DATA_W-DIG_W){1'b0}}, dig};
  endfunction

`ifdef BCD_DIGIT_CHECK_EN
  logic err_p0;

  function automatic logic digit_bad(input logic [DIG_W-1:0] d);
    return d > 4'd9;
  endfunction
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start_input) begin
          accept    = 1'b1;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (idx_p0 == 2'd0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: digit capture; stage p1: accumulation; result registered at DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_p0        <= '0;
      idx_p0        <= 2'd0;
      acc_p1        <= '0;
      numero_output <= '0;
      busy_output   <= 1'b0;
      done_output   <= 1'b0;
    end else begin
      done_output <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dig_p0      <= {milesimas_input, centenas_input, decenas_input, unidades_input};
            acc_p1      <= '0;
            idx_p0      <= 2'd3;
            busy_output <= 1'b1;
          end
        end
        ACC: begin
          acc_p1 <= mul10_add(acc_p1, dig_p0[idx_p0]);
          idx_p0 <= idx_p0 - 2'd1;
        end
        DONE: begin
`ifdef BCD_DIGIT_CHECK_EN
          numero_output <= err_p0 ? '0 : acc_p1;
`else
          numero_output <= acc_p1;
`endif
          done_output <= 1'b1;
          busy_output <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  // The flag is latched at capture but only becomes visible at DONE, then holds until the next start
  always_ff @(posedge clk) begin
    if (rst) begin
      err_p0       <= 1'b0;
      error_output <= 1'b0;
    end else begin
      if (accept) begin
        err_p0 <= digit_bad(milesimas_input) | digit_bad(centenas_input) |
                  digit_bad(decenas_input)   | digit_bad(unidades_input);
        error_output <= 1'b0;
      end else if (state == DONE) begin
        error_output <= err_p0;
      end
    end
  end
`else
  assign error_output = 1'b0;
`endif

endmodule

// File: tb/tb_module_bcd_binario.sv
// Directed self-checking bench for module_bcd_binario; expected values are hand-computed constants.
module tb_module_bcd_binario;

  logic        clk;
  logic        rst;
  logic        start_input;
  logic [3:0]  unidades_input, decenas_input, centenas_input, milesimas_input;
  logic [15:0] numero_output;
  logic        busy_output, done_output, error_output;

  int n_cmp;
  int n_err;

  module_bcd_binario dut (
    .clk             (clk),
    .rst             (rst),
    .start_input     (start_input),
    .unidades_input  (unidades_input),
    .decenas_input   (decenas_input),
    .centenas_input  (centenas_input),
    .milesimas_input (milesimas_input),
    .numero_output   (numero_output),
    .busy_output     (busy_output),
    .done_output     (done_output),
    .error_output    (error_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_digits(input logic [3:0] m, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] u);
    milesimas_input = m;
    centenas_input  = c;
    decenas_input   = d;
    unidades_input  = u;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_input = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) tick();
    n_cmp++;
    if ({numero_output, busy_output, done_output, error_output} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got numero=%0d busy=%b done=%b err=%b, want all 0",
               numero_output, busy_output, done_output, error_output);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({busy_output, done_output} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy_output, done_output);
    end
  endtask

  task automatic test_basic_1234;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    start_input = 1'b1;
    tick();
    start_input = 1'b0;
    n_cmp++;
    if ({busy_output, done_output, numero_output} !== {2'b10, 16'd0}) begin
      n_err++;
      $display("FAIL basic_after_e0: got busy=%b done=%b numero=%0d, want 1 0 0",
               busy_output, done_output, numero_output);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if ({busy_output, done_output} !== 2'b10) begin
        n_err++;
        $display("FAIL basic_busy_e%0d: got busy=%b done=%b, want 1 0", k, busy_output, done_output);
      end
    end
    tick();
    n_cmp++;
    if ({busy_output, done_output, error_output, numero_output} !== {3'b010, 16'd1234}) begin
      n_err++;
      $display("FAIL basic_done: got busy=%b done=%b err=%b numero=%0d, want 0 1 0 1234",
               busy_output, done_output, error_output, numero_output);
    end
    tick();
    n_cmp++;
    if ({done_output, numero_output} !== {1'b0, 16'h04D2}) begin
      n_err++;
      $display("FAIL basic_hold: got done=%b numero=%0d, want 0 1234", done_output, numero_output);
    end
  endtask

  task automatic test_back_to_back;
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    start_input = 1'b1;
    tick();
    start_input = 1'b0;
    repeat (4) tick();
    tick();
    n_cmp++;
    if ({done_output, numero_output} !== {1'b1, 16'd9999}) begin
      n_err++;
      $display("FAIL b2b_first: got done=%b numero=%0d, want 1 9999", done_output, numero_output);
    end
    // start held during the done cycle must be accepted
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    start_input = 1'b1;
    tick();
    start_input = 1'b0;
    n_cmp++;
    if ({busy_output, done_output} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy_output, done_output);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k < 5) begin
        n_cmp++;
        if (done_output !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_early_done_c%0d: got done=%b, want 0", k, done_output);
        end
      end
    end
    tick();
    n_cmp++;
    if ({done_output, busy_output, numero_output} !== {2'b10, 16'd0}) begin
      n_err++;
      $display("FAIL b2b_second: got done=%b busy=%b numero=%0d, want 1 0 0",
               done_output, busy_output, numero_output);
    end
    tick();
  endtask

  task automatic test_ignore_start;
    int dones;
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    start_input = 1'b1;
    tick();
    start_input = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        set_digits(4'd1, 4'd1, 4'd1, 4'd1);
        start_input = 1'b1;
      end else if (k == 2) begin
        start_input = 1'b0;
      end
    end
    tick();
    n_cmp++;
    if ({done_output, numero_output} !== {1'b1, 16'd5678}) begin
      n_err++;
      $display("FAIL ignore_result: got done=%b numero=%0d, want 1 5678", done_output, numero_output);
    end
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done_output === 1'b1 || busy_output === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0 || numero_output !== 16'd5678) begin
      n_err++;
      $display("FAIL ignore_no_second: got %0d busy/done cycles numero=%0d, want 0 5678",
               dones, numero_output);
    end
  endtask

  task automatic test_abort;
    int dones;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    start_input = 1'b1;
    tick();
    start_input = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({numero_output, busy_output, done_output, error_output} !== 19'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got numero=%0d busy=%b done=%b err=%b, want all 0",
               numero_output, busy_output, done_output, error_output);
    end
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done_output === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", dones);
    end
    set_digits(4'd0, 4'd0, 4'd4, 4'd2);
    start_input = 1'b1;
    tick();
    start_input = 1'b0;
    repeat (4) tick();
    tick();
    n_cmp++;
    if ({done_output, numero_output} !== {1'b1, 16'd42}) begin
      n_err++;
      $display("FAIL abort_restart: got done=%b numero=%0d, want 1 42", done_output, numero_output);
    end
    tick();
  endtask

  task automatic test_digit_check;
    logic [15:0] exp_num;
    logic        exp_err;
`ifdef BCD_DIGIT_CHECK_EN
    exp_num = 16'd0;
    exp_err = 1'b1;
`else
    exp_num = 16'd1304;
    exp_err = 1'b0;
`endif
    set_digits(4'd1, 4'd2, 4'hA, 4'd4);
    start_input = 1'b1;
    tick();
    start_input = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++;
      if ({busy_output, done_output, error_output} !== 3'b100) begin
        n_err++;
        $display("FAIL digit_busy_e%0d: got busy=%b done=%b err=%b, want 1 0 0",
                 k, busy_output, done_output, error_output);
      end
    end
    tick();
    n_cmp++;
    if ({done_output, error_output, numero_output} !== {1'b1, exp_err, exp_num}) begin
      n_err++;
      $display("FAIL digit_done: got done=%b err=%b numero=%0d, want 1 %b %0d",
               done_output, error_output, numero_output, exp_err, exp_num);
    end
    repeat (3) tick();
    n_cmp++;
    if (error_output !== exp_err) begin
      n_err++;
      $display("FAIL digit_err_hold: got err=%b, want %b", error_output, exp_err);
    end
    set_digits(4'd0, 4'd0, 4'd0, 4'd7);
    start_input = 1'b1;
    tick();
    start_input = 1'b0;
    n_cmp++;
    if ({busy_output, error_output} !== 2'b10) begin
      n_err++;
      $display("FAIL digit_err_clear: got busy=%b err=%b, want 1 0", busy_output, error_output);
    end
    repeat (4) tick();
    tick();
    n_cmp++;
    if ({done_output, error_output, numero_output} !== {2'b10, 16'd7}) begin
      n_err++;
      $display("FAIL digit_next_valid: got done=%b err=%b numero=%0d, want 1 0 7",
               done_output, error_output, numero_output);
    end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start_input = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    test_reset();
    test_basic_1234();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_digit_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
